// File: rtl/alu_result_stage.sv
// Result stage for the 4-bit ALU: tags each result with its select code and flags, then buffers it in a FIFO behind valid/ready.
// Optional saturating carry statistics counter enabled by defining ALU_STATS_EN.
module alu_result_stage #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_sel,
  input  logic [DATA_W:0]          in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [2:0]               out_sel,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               carry_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 5;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic               push_carry;
  logic               push_zero;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    in_ready   = (count < FULL_COUNT);
    out_valid  = (count != '0);
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    // Logic ops never produce a carry; bit DATA_W is meaningless for them (nand sets it).
    push_carry = in_sel[2] ? 1'b0 : in_result[DATA_W];
    push_zero  = (in_result[DATA_W-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_sel, in_result[DATA_W-1:0], push_carry, push_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    head      = mem[rd_ptr];
    out_sel   = head[ENTRY_W-1 -: 3];
    out_data  = head[DATA_W+1:2];
    out_carry = head[1];
    out_zero  = head[0];
  end

`ifdef ALU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_count <= '0;
    end else if (push && push_carry && (carry_count != '1)) begin
      carry_count <= carry_count + 1'b1;
    end
  end
`else
  assign carry_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle, plus directed literal expectations.
module tb_alu_result_stage;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [4:0] in_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_sel;
  logic       out_carry;
  logic       out_zero;
  logic [2:0] count;
  logic [7:0] carry_count;

  alu_result_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .out_carry(out_carry), .out_zero(out_zero),
    .count(count), .carry_count(carry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] data;
    logic       c;
    logic       z;
  } entry_t;

  entry_t q[$];
  int     m_stats;
  bit     started;
  int     checks;
  int     passes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Reference model: a plain queue updated with the inputs seen at each rising edge.
  initial begin
    bit     do_push;
    bit     do_pop;
    entry_t e;
    m_stats = 0;
    started = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_stats = 0;
        started = 1;
      end else if (started) begin
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = out_ready && (q.size() != 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.sel  = in_sel;
          e.data = in_result[3:0];
          e.c    = (in_sel >= 3'd4) ? 1'b0 : in_result[4];
          e.z    = (in_result[3:0] == 4'd0);
          q.push_back(e);
`ifdef ALU_STATS_EN
          if (e.c && m_stats < 255) m_stats++;
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("m_carry_count", 32'(carry_count), 32'(m_stats));
        if (q.size() != 0) begin
          chk("m_out_data", 32'(out_data), 32'(q[0].data));
          chk("m_out_sel", 32'(out_sel), 32'(q[0].sel));
          chk("m_out_carry", 32'(out_carry), 32'(q[0].c));
          chk("m_out_zero", 32'(out_zero), 32'(q[0].z));
        end
      end
    end
  end

  // Drive at the falling edge, return at the next falling edge (after one rising edge).
  task automatic step(input logic v, input logic [2:0] s, input logic [4:0] r, input logic ordy);
    in_valid  = v;
    in_sel    = s;
    in_result = r;
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_result = 5'd0;
    out_ready = 1'b0;
    @(negedge clk);
    step(0, 3'd0, 5'd0, 0);
    step(0, 3'd0, 5'd0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_carry_count", 32'(carry_count), 0);
    rst_n = 1'b1;

    // Add 9+8
    step(1, 3'b000, 5'b10001, 1);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_data", 32'(out_data), 32'h1);
    chk("add_carry", 32'(out_carry), 1);
    chk("add_zero", 32'(out_zero), 0);
    chk("add_sel", 32'(out_sel), 0);
    step(0, 3'd0, 5'd0, 1);
    chk("add_drained", 32'(out_valid), 0);

    // Sub 3-5 then nand F,F
    step(1, 3'b010, 5'b11110, 0);
    chk("sub_data", 32'(out_data), 32'hE);
    chk("sub_carry", 32'(out_carry), 1);
    step(1, 3'b101, 5'b10000, 1);
    chk("nand_data", 32'(out_data), 0);
    chk("nand_zero", 32'(out_zero), 1);
    chk("nand_carry", 32'(out_carry), 0);
    chk("nand_sel", 32'(out_sel), 5);
    step(0, 3'd0, 5'd0, 1);

    // Fill with 1..4, 5th rejected
    for (int unsigned i = 1; i <= 4; i++) step(1, 3'b000, 5'(i), 0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    step(1, 3'b000, 5'd5, 0);
    chk("full_reject_count", 32'(count), 4);
    chk("full_head1", 32'(out_data), 1);
    // Push+pop while full: pop only
    step(1, 3'b000, 5'd9, 1);
    chk("full_pp_count", 32'(count), 3);
    chk("full_pp_ready", 32'(in_ready), 1);
    for (int unsigned i = 2; i <= 4; i++) begin
      chk("drain_order", 32'(out_data), 32'(i));
      step(0, 3'd0, 5'd0, 1);
    end
    chk("drain_count", 32'(count), 0);
    step(0, 3'd0, 5'd0, 1);
    chk("empty_pop_ignored", 32'(count), 0);

    // Steady push+pop at count 2
    step(1, 3'b001, 5'd10, 0);
    step(1, 3'b001, 5'd11, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 3'b011, 5'(12 + i), 1);
      chk("pp_count", 32'(count), 2);
      chk("pp_head", 32'(out_data), 32'(11 + i));
    end
    step(1, 3'b000, 5'd15, 0);
    chk("pre_rst_count", 32'(count), 3);
    rst_n = 1'b0;
    step(0, 3'd0, 5'd0, 0);
    rst_n = 1'b1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);

    // Logic op with bit 4 set must not count; then one add carry
    step(1, 3'b110, 5'b10011, 1);
    step(1, 3'b000, 5'b11000, 1);
    step(0, 3'd0, 5'd0, 1);
`ifdef ALU_STATS_EN
    chk("stats_one", 32'(carry_count), 1);
`else
    chk("stats_off_one", 32'(carry_count), 0);
`endif

    // 260 carry pushes, interleaved with non-carry nand entries
    for (int unsigned i = 0; i < 260; i++) begin
      step(1, (i % 2 == 0) ? 3'b000 : 3'b010, 5'b10000 | 5'(i % 16), 1);
      if (i % 50 == 0) step(1, 3'b101, 5'b11111, 1);
    end
    step(0, 3'd0, 5'd0, 1);
    step(0, 3'd0, 5'd0, 1);
`ifdef ALU_STATS_EN
    chk("stats_sat", 32'(carry_count), 255);
`else
    chk("stats_off", 32'(carry_count), 0);
`endif
    chk("end_count", 32'(count), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Downstream stage of the 4-bit ALU. It captures each ALU result with the select code that produced it and derives carry/borrow and zero flags. Results are buffered in a small FIFO and presented to the consumer over a valid/ready handshake. The stage decouples the combinational ALU from a consumer that may stall.

Parameters:
DATA_W, 4, ALU operand width; the result bus is DATA_W+1 bits.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock; all logic acts on its rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  ALU result and select are valid this cycle
in_ready  output  1  stage can accept an entry this cycle
in_sel  input  3  ALU select code that produced in_result
in_result  input  DATA_W+1  ALU output
out_valid  output  1  head entry is valid
out_ready  input  1  consumer takes the head entry this cycle
out_data  output  DATA_W  head entry, in_result[DATA_W-1:0]
out_sel  output  3  head entry select code
out_carry  output  1  head entry carry/borrow flag
out_zero  output  1  head entry zero flag
count  output  $clog2(DEPTH)+1  current occupancy
carry_count  output  8  statistics counter; see Optional Feature

Behaviour:
- Reset is synchronous: when rst_n=0 at a clk edge, count=0, read and write pointers=0, carry_count=0. out_valid=0 follows from count=0. Storage contents are not reset.
- in_ready = (count < DEPTH). It is a function of state only; there is no combinational path from out_ready.
- Push occurs when in_valid && in_ready. The stored entry is {in_sel, in_result[DATA_W-1:0], carry, zero}.
- Pop occurs when out_valid && out_ready. out_valid = (count != 0).
- out_* always reflect the entry at the read pointer. When out_valid=0, their values are don't-care.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass from in_* to out_*.
- Flag derivation at push:
  - in_sel 000 (add) or 001 (inc): carry = in_result[DATA_W].
  - in_sel 010 (sub) or 011 (dec): carry = in_result[DATA_W]. This acts as borrow: 1 when the operand was less than the subtrahend.
  - in_sel 1xx (and, nand, or, xor): carry = 0 unconditionally. For these ops in_result[DATA_W] is ignored; nand sets this bit to 1.
  - zero = (in_result[DATA_W-1:0] == 0) for every op.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push only: count+1. Pop only: count-1.
- Full (count == DEPTH): in_ready=0 and in_valid is ignored. A pop in that cycle still proceeds, and in_ready is 1 in the next cycle.
- Empty: out_ready is ignored and count stays 0.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Reset asserted mid-stream discards all buffered entries. in_ready=1 and out_valid=0 in the cycle after the reset edge.
- in_sel and in_result are sampled only on an accepted push.

Optional Feature:
- Macro: ALU_STATS_EN.
- Defined: carry_count increments by 1 on each accepted push whose derived carry=1. It saturates at 255 and clears only on reset.
- Undefined: carry_count is tied to 0 and no counter logic is built. The port is present in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> count=0, out_valid=0, in_ready=1, carry_count=0.
- Add: push sel=000, result=5'b10001 (9+8), out_ready=1 -> next cycle out_valid=1, out_data=4'h1, out_carry=1, out_zero=0, out_sel=000.
- Sub and nand:
  - Push sel=010, result=5'b11110 (3-5) -> out_data=4'hE, out_carry=1.
  - Then push sel=101, result=5'b10000 (nand F,F) -> out_data=0, out_zero=1, out_carry=0.
- Full/backpressure: out_ready=0, push 4 entries with values 1..4 -> count=4, in_ready=0, and a 5th push (value 5) is not accepted. Then drain with out_ready=1 -> outputs 1,2,3,4 in order, count returns to 0.
- Simultaneous events:
  - At count=2, push and pop together for 3 cycles -> count stays 2 and order is preserved.
  - At count=4, push and pop together -> pop only, count=3.
- Reset and statistics:
  - Assert rst_n=0 at count=3 -> count=0 and out_valid=0 next cycle.
  - With ALU_STATS_EN, push 260 carry entries -> carry_count=255.
  - Without ALU_STATS_EN -> carry_count=0.
